// File: rtl/demux_pkg.sv
// Shared definitions for the demux capture bank: channel count, select width
// and the per-channel occupancy state.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [0:0] {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/demux_cap_ch.sv
// One capture slot: holding register, EMPTY/FULL occupancy FSM and a sticky
// overflow flag that records writes dropped while the slot was occupied.
module demux_cap_ch
  import demux_pkg::*;
#(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [width-1:0] d,
  input  logic             rd,
  input  logic             clr,
  output logic [width-1:0] q,
  output logic             full,
  output logic             ovf
);

  ch_state_e        state_q;
  logic [width-1:0] q_q;
  logic             ovf_q;
  logic             drop;

  // A write is lost only when the slot is occupied and not drained this cycle.
  assign drop = we && (state_q == CH_FULL) && !rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_EMPTY;
      q_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        CH_EMPTY: begin
          if (we) begin
            q_q     <= d;
            state_q <= CH_FULL;
          end
        end
        CH_FULL: begin
          if (we && rd) begin
            q_q <= d;
          end else if (!we && rd) begin
            state_q <= CH_EMPTY;
          end
        end
        default: state_q <= CH_EMPTY;
      endcase
      // A new drop outranks a simultaneous clear.
      ovf_q <= drop | (ovf_q & ~clr);
    end
  end

  assign q    = q_q;
  assign full = (state_q == CH_FULL);
  assign ovf  = ovf_q;

endmodule

// File: rtl/demux_capture_4ch.sv
// Four-channel capture bank behind a 1-to-4 demux: steers the selected demux
// output into its channel slot and exposes per-channel data, full and overflow.
module demux_capture_4ch
  import demux_pkg::*;
#(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] sel,
  input  logic [width-1:0] d0,
  input  logic [width-1:0] d1,
  input  logic [width-1:0] d2,
  input  logic [width-1:0] d3,
  input  logic [3:0]       rd,
  input  logic             clr,
  output logic [width-1:0] q0,
  output logic [width-1:0] q1,
  output logic [width-1:0] q2,
  output logic [width-1:0] q3,
  output logic [3:0]       full,
  output logic [3:0]       ovf
);

  logic [width-1:0] d_arr [NUM_CH];
  logic [width-1:0] q_arr [NUM_CH];
  logic [width-1:0] d_sel;

  assign d_arr[0] = d0;
  assign d_arr[1] = d1;
  assign d_arr[2] = d2;
  assign d_arr[3] = d3;

  // Only the selected demux leg carries data; the others are ignored.
  assign d_sel = d_arr[sel];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_cap_ch #(
      .width(width)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (wr_en && (sel == SEL_W'(k))),
      .d    (d_sel),
      .rd   (rd[k]),
      .clr  (clr),
      .q    (q_arr[k]),
      .full (full[k]),
      .ovf  (ovf[k])
    );
  end

  assign q0 = q_arr[0];
  assign q1 = q_arr[1];
  assign q2 = q_arr[2];
  assign q3 = q_arr[3];

endmodule

// File: tb/tb_demux_capture_4ch.sv
// Self-checking bench for demux_capture_4ch: directed vector table, async
// reset sequences and randomized traffic against a behavioural model.
module tb_demux_capture_4ch;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] sel;
  logic [3:0] d [4];
  logic [3:0] rd;
  logic       clr;
  logic [3:0] q0, q1, q2, q3;
  logic [3:0] full;
  logic [3:0] ovf;

  int checks = 0;
  int errors = 0;

  demux_capture_4ch #(
    .width(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .sel  (sel),
    .d0   (d[0]),
    .d1   (d[1]),
    .d2   (d[2]),
    .d3   (d[3]),
    .rd   (rd),
    .clr  (clr),
    .q0   (q0),
    .q1   (q1),
    .q2   (q2),
    .q3   (q3),
    .full (full),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  sel;
    logic [3:0]  dv;
    logic [3:0]  rd;
    logic        clr;
    logic [15:0] eq;
    logic [3:0]  ef;
    logic [3:0]  eo;
  } vec_t;

  vec_t tbl [12];

  // Behavioural model state
  logic [3:0] mq [4];
  logic [3:0] mfull;
  logic [3:0] movf;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] eq, input logic [3:0] ef,
                           input logic [3:0] eo);
    check({tag, " q"}, {q3, q2, q1, q0}, eq);
    check({tag, " full"}, {12'h0, full}, {12'h0, ef});
    check({tag, " ovf"}, {12'h0, ovf}, {12'h0, eo});
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic [3:0] dv,
                       input logic [3:0] r, input logic c);
    wr_en = w;
    sel   = s;
    for (int k = 0; k < 4; k++) d[k] = (w && s == 2'(k)) ? dv : 4'h0;
    rd    = r;
    clr   = c;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    idle();

    tbl[0]  = '{1'b1, 2'd0, 4'hA, 4'h0, 1'b0, 16'h000A, 4'h1, 4'h0};
    tbl[1]  = '{1'b1, 2'd1, 4'hB, 4'h0, 1'b0, 16'h00BA, 4'h3, 4'h0};
    tbl[2]  = '{1'b1, 2'd2, 4'hC, 4'h0, 1'b0, 16'h0CBA, 4'h7, 4'h0};
    tbl[3]  = '{1'b1, 2'd3, 4'hD, 4'h0, 1'b0, 16'hDCBA, 4'hF, 4'h0};
    tbl[4]  = '{1'b1, 2'd1, 4'h5, 4'h0, 1'b0, 16'hDCBA, 4'hF, 4'h2};
    tbl[5]  = '{1'b1, 2'd2, 4'h7, 4'h4, 1'b0, 16'hD7BA, 4'hF, 4'h2};
    tbl[6]  = '{1'b0, 2'd0, 4'h0, 4'h9, 1'b0, 16'hD7BA, 4'h6, 4'h2};
    tbl[7]  = '{1'b0, 2'd0, 4'h0, 4'h9, 1'b0, 16'hD7BA, 4'h6, 4'h2};
    tbl[8]  = '{1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 16'hD7BA, 4'h6, 4'h0};
    tbl[9]  = '{1'b1, 2'd3, 4'hE, 4'h0, 1'b0, 16'hE7BA, 4'hE, 4'h0};
    tbl[10] = '{1'b1, 2'd3, 4'hF, 4'h0, 1'b1, 16'hE7BA, 4'hE, 4'h8};
    tbl[11] = '{1'b1, 2'd0, 4'h9, 4'h0, 1'b1, 16'hE7B9, 4'hF, 4'h0};

    #1 rst_n = 1'b0;
    #1 check_all("reset", 16'h0, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].wr, tbl[i].sel, tbl[i].dv, tbl[i].rd, tbl[i].clr);
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ef, tbl[i].eo);
    end

    // Async reset mid-run with all channels full and one ovf set
    @(negedge clk);
    drive(1'b1, 2'd2, 4'h3, 4'h0, 1'b0);
    @(negedge clk);
    idle();
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 16'h0, 4'h0, 4'h0);
    // Held reset across an edge with a write pending: nothing captured
    drive(1'b1, 2'd1, 4'h6, 4'h0, 1'b0);
    @(posedge clk);
    #1 check_all("rst_hold", 16'h0, 4'h0, 4'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_all("rst_release", 16'h0, 4'h0, 4'h0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 4; k++) mq[k] = 4'h0;
    mfull = 4'h0;
    movf  = 4'h0;
    for (int n = 0; n < 400; n++) begin
      logic       w;
      logic [1:0] s;
      logic [3:0] dv;
      logic [3:0] r;
      logic       c;
      w  = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      dv = 4'($urandom);
      r  = 4'($urandom) & 4'($urandom);
      c  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      wr_en = w;
      sel   = s;
      rd    = r;
      clr   = c;
      // Unselected legs carry junk; the bank must ignore them.
      for (int k = 0; k < 4; k++) d[k] = (s == 2'(k)) ? dv : 4'($urandom);
      if (c) movf = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (w && s == 2'(k)) begin
          if (!mfull[k] || r[k]) begin
            mq[k]    = dv;
            mfull[k] = 1'b1;
          end else begin
            movf[k] = 1'b1;
          end
        end else if (r[k]) begin
          mfull[k] = 1'b0;
        end
      end
      @(posedge clk);
      #1 check_all($sformatf("rand%0d", n), {mq[3], mq[2], mq[1], mq[0]}, mfull, movf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
